// File: rtl/ic_refill_ctrl.sv
// Instruction-cache refill controller: victim choice, line fetch, tag/LRU update and whole-cache
// flush sequencing for a 4-way, 256-line, 16-byte-line cache.
package ic_refill_pkg;
    localparam int unsigned ADDR_BITS = 27;
    localparam int unsigned WAYS      = 4;
    localparam int unsigned TAG_BITS  = 15;

    typedef logic [7:0]                ic_line_t;
    typedef logic [1:0]                ic_way_t;
    typedef logic [1:0]                ic_waddr_t;
    typedef logic [WAYS-1:0][1:0]      ic_lru_t;   // rank of way i in [i]; 0 = most recent
    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
    } ic_tag_entry_t;
endpackage

module ic_refill_ctrl
    import ic_refill_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_valid,
    output logic                 miss_ready,
    input  logic [ADDR_BITS-1:0] miss_addr,
    input  logic                 flush_req,
    output logic                 flush_done,
    output ic_line_t             lk_line,
    input  ic_lru_t              lk_lru,
    input  logic [WAYS-1:0]      lk_valid,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    input  logic                 mem_rsp_valid,
    input  logic [31:0]          mem_rsp_data,
    output logic                 dw_en,
    output ic_way_t              dw_way,
    output ic_line_t             dw_line,
    output ic_waddr_t            dw_word,
    output logic [31:0]          dw_data,
    output logic                 tw_en,
    output logic                 tw_all,
    output ic_way_t              tw_way,
    output ic_line_t             tw_line,
    output ic_tag_entry_t        tw_entry,
    output logic                 lru_we,
    output ic_line_t             lru_line,
    output ic_lru_t              lru_wdata,
    output logic                 busy,
    output logic                 fill_done,
    output ic_way_t              fill_way
);

    typedef enum logic [2:0] {
        StIdle, StFlush, StLookup, StInval, StReq, StFill, StCommit
    } state_e;

    state_e                state_q, state_d;
    logic [TAG_BITS-1:0]   tag_q;
    ic_line_t              line_q;
    ic_way_t               victim_q;
    ic_lru_t               lru_q;
    ic_waddr_t             beat_q;
    ic_line_t              flush_cnt_q;

    ic_way_t               victim_sel;
    logic                  found_invalid;
    ic_lru_t               lru_upd;
    ic_lru_t               lru_reset_val;

    // Prefer an empty way; only evict the least-recently-used way when all are valid.
    always_comb begin
        victim_sel    = '0;
        found_invalid = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (!found_invalid && !lk_valid[i]) begin
                victim_sel    = ic_way_t'(i);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int i = 0; i < WAYS; i++) begin
                if (lk_lru[i] == 2'(WAYS - 1)) victim_sel = ic_way_t'(i);
            end
        end
    end

    always_comb begin
        lru_upd       = lru_q;
        lru_reset_val = '0;
        for (int i = 0; i < WAYS; i++) begin
            lru_reset_val[i] = ic_way_t'(i);
            if (ic_way_t'(i) == victim_q) begin
                lru_upd[i] = '0;
            end else if (lru_q[i] < lru_q[victim_q]) begin
                lru_upd[i] = lru_q[i] + 2'd1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        miss_ready    = 1'b0;
        flush_done    = 1'b0;
        lk_line       = line_q;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        dw_en         = 1'b0;
        dw_way        = '0;
        dw_line       = '0;
        dw_word       = '0;
        dw_data       = '0;
        tw_en         = 1'b0;
        tw_all        = 1'b0;
        tw_way        = '0;
        tw_line       = '0;
        tw_entry      = '0;
        lru_we        = 1'b0;
        lru_line      = '0;
        lru_wdata     = '0;
        busy          = (state_q != StIdle);
        fill_done     = 1'b0;
        fill_way      = '0;

        unique case (state_q)
            StIdle: begin
                lk_line    = miss_addr[11:4];
                miss_ready = !flush_req;
                if (flush_req)       state_d = StFlush;
                else if (miss_valid) state_d = StLookup;
            end
            StFlush: begin
                tw_en     = 1'b1;
                tw_all    = 1'b1;
                tw_line   = flush_cnt_q;
                lru_we    = 1'b1;
                lru_line  = flush_cnt_q;
                lru_wdata = lru_reset_val;
                if (flush_cnt_q == 8'hff) begin
                    flush_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            StLookup: state_d = StInval;
            StInval: begin
                // Invalidate before fetching so a partially written line can never hit.
                tw_en   = 1'b1;
                tw_way  = victim_q;
                tw_line = line_q;
                state_d = StReq;
            end
            StReq: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag_q, line_q, 4'b0000};
                if (mem_req_ready) state_d = StFill;
            end
            StFill: begin
                if (mem_rsp_valid) begin
                    dw_en   = 1'b1;
                    dw_way  = victim_q;
                    dw_line = line_q;
                    dw_word = beat_q;
                    dw_data = mem_rsp_data;
                    if (beat_q == 2'd3) state_d = StCommit;
                end
            end
            StCommit: begin
                tw_en     = 1'b1;
                tw_way    = victim_q;
                tw_line   = line_q;
                tw_entry  = '{valid: 1'b1, tag: tag_q};
                lru_we    = 1'b1;
                lru_line  = line_q;
                lru_wdata = lru_upd;
                fill_done = 1'b1;
                fill_way  = victim_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Reset forces every output low, regardless of the state being left.
        if (rst) begin
            miss_ready    = 1'b0;
            flush_done    = 1'b0;
            lk_line       = '0;
            mem_req_valid = 1'b0;
            mem_req_addr  = '0;
            dw_en         = 1'b0;
            dw_way        = '0;
            dw_line       = '0;
            dw_word       = '0;
            dw_data       = '0;
            tw_en         = 1'b0;
            tw_all        = 1'b0;
            tw_way        = '0;
            tw_line       = '0;
            tw_entry      = '0;
            lru_we        = 1'b0;
            lru_line      = '0;
            lru_wdata     = '0;
            busy          = 1'b0;
            fill_done     = 1'b0;
            fill_way      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tag_q       <= '0;
            line_q      <= '0;
            victim_q    <= '0;
            lru_q       <= '0;
            beat_q      <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (!flush_req && miss_valid) begin
                        tag_q  <= miss_addr[26:12];
                        line_q <= miss_addr[11:4];
                    end
                end
                StFlush:  flush_cnt_q <= flush_cnt_q + 8'd1;
                StLookup: begin
                    victim_q <= victim_sel;
                    lru_q    <= lk_lru;
                end
                StFill: begin
                    if (mem_rsp_valid) beat_q <= beat_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ic_refill_ctrl.sv
// Directed bench for ic_refill_ctrl: data writes go through a scoreboard queue, control outputs
// are checked against hand-derived values.
module tb_ic_refill_ctrl;
    import ic_refill_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 miss_valid;
    logic                 miss_ready;
    logic [ADDR_BITS-1:0] miss_addr;
    logic                 flush_req;
    logic                 flush_done;
    ic_line_t             lk_line;
    ic_lru_t              lk_lru;
    logic [WAYS-1:0]      lk_valid;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic                 mem_rsp_valid;
    logic [31:0]          mem_rsp_data;
    logic                 dw_en;
    ic_way_t              dw_way;
    ic_line_t             dw_line;
    ic_waddr_t            dw_word;
    logic [31:0]          dw_data;
    logic                 tw_en;
    logic                 tw_all;
    ic_way_t              tw_way;
    ic_line_t             tw_line;
    ic_tag_entry_t        tw_entry;
    logic                 lru_we;
    ic_line_t             lru_line;
    ic_lru_t              lru_wdata;
    logic                 busy;
    logic                 fill_done;
    ic_way_t              fill_way;

    int checks   = 0;
    int failures = 0;
    int fill_cnt = 0;
    logic [43:0] dw_q[$];

    ic_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .flush_req(flush_req), .flush_done(flush_done),
        .lk_line(lk_line), .lk_lru(lk_lru), .lk_valid(lk_valid),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .dw_en(dw_en), .dw_way(dw_way), .dw_line(dw_line), .dw_word(dw_word),
        .dw_data(dw_data),
        .tw_en(tw_en), .tw_all(tw_all), .tw_way(tw_way), .tw_line(tw_line),
        .tw_entry(tw_entry),
        .lru_we(lru_we), .lru_line(lru_line), .lru_wdata(lru_wdata),
        .busy(busy), .fill_done(fill_done), .fill_way(fill_way)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Data-write scoreboard: every dw_en must match the oldest expected beat.
    always @(negedge clk) begin
        if (fill_done) fill_cnt++;
        if (dw_en) begin
            if (dw_q.size() == 0) begin
                chk("dw_unexpected", {20'h0, dw_way, dw_line, dw_word, dw_data}, 64'h0);
            end else begin
                chk("dw_write", {20'h0, dw_way, dw_line, dw_word, dw_data},
                    {20'h0, dw_q.pop_front()});
            end
        end
    end

    task automatic run_miss(input logic [26:0] addr, input logic [3:0] vld, input ic_lru_t lru,
                            input ic_way_t exp_way, input ic_lru_t exp_lru,
                            input int stall, input int gap);
        logic [31:0] d;
        lk_valid   = vld;
        lk_lru     = lru;
        miss_addr  = addr;
        miss_valid = 1'b1;
        #1 chk("idle_lk_line", lk_line, addr[11:4]);
        chk("idle_miss_ready", miss_ready, 1);
        step();
        miss_valid = 1'b0;
        miss_addr  = '0;
        #1 chk("lookup_busy", busy, 1);
        chk("lookup_lk_line", lk_line, addr[11:4]);
        chk("lookup_tw_en", tw_en, 0);
        step();
        #1 chk("inval_tw", {tw_en, tw_all, tw_way, tw_line, tw_entry.valid},
               {1'b1, 1'b0, exp_way, addr[11:4], 1'b0});
        chk("inval_mem_req_valid", mem_req_valid, 0);
        step();
        for (int s = 0; s < stall; s++) begin
            #1 chk("req_stall", {mem_req_valid, mem_req_addr}, {1'b1, addr[26:4], 4'h0});
            step();
        end
        mem_req_ready = 1'b1;
        #1 chk("req_hs", {mem_req_valid, mem_req_addr}, {1'b1, addr[26:4], 4'h0});
        step();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                #1 chk("fill_gap_dw_en", dw_en, 0);
                step();
            end
            d             = $urandom;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = d;
            dw_q.push_back({exp_way, addr[11:4], 2'(b), d});
            step();
            mem_rsp_valid = 1'b0;
        end
        #1 chk("commit_tw", {tw_en, tw_way, tw_line, tw_entry},
               {1'b1, exp_way, addr[11:4], 1'b1, addr[26:12]});
        chk("commit_lru", {lru_we, lru_line, lru_wdata}, {1'b1, addr[11:4], exp_lru});
        chk("commit_fill", {fill_done, fill_way}, {1'b1, exp_way});
        step();
        #1 chk("post_idle", {busy, fill_done, tw_en, lru_we}, 0);
    endtask

    initial begin
        int bad;
        rst           = 1'b1;
        miss_valid    = 1'b1;
        miss_addr     = 27'h0123450;
        flush_req     = 1'b0;
        lk_lru        = '0;
        lk_valid      = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        step();
        step();
        #1 chk("rst_outputs", {miss_ready, busy, tw_en, lru_we, dw_en, lk_line}, 0);
        rst        = 1'b0;
        miss_valid = 1'b0;
        step();
        #1 chk("rst_release_ready", miss_ready, 1);
        step();

        // Victim from invalid way 2; old ranks w3:0 w2:1 w1:2 w0:3 -> w3:1 w2:0 w1:2 w0:3.
        run_miss(27'h0123450, 4'b1011, {2'd0, 2'd1, 2'd2, 2'd3}, 2'd2,
                 {2'd1, 2'd0, 2'd2, 2'd3}, 5, 2);
        // All valid, ranks w3:1 w2:3 w1:0 w0:2 -> victim 2, new w3:2 w2:0 w1:1 w0:3.
        run_miss(27'h7abcde0, 4'b1111, {2'd1, 2'd3, 2'd0, 2'd2}, 2'd2,
                 {2'd2, 2'd0, 2'd1, 2'd3}, 0, 0);
        chk("fill_done_count", fill_cnt, 2);

        // Flush wins over a simultaneous miss.
        step();
        flush_req  = 1'b1;
        miss_valid = 1'b1;
        miss_addr  = 27'h0123450;
        lk_valid   = 4'b0000;
        #1 chk("flush_miss_ready", miss_ready, 0);
        step();
        flush_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            #1;
            if (tw_en !== 1'b1 || tw_all !== 1'b1 || tw_line !== 8'(i) ||
                tw_entry.valid !== 1'b0 || lru_we !== 1'b1 || lru_line !== 8'(i) ||
                lru_wdata !== 8'he4 || flush_done !== (i == 255) || miss_ready !== 1'b0)
                bad++;
            step();
        end
        chk("flush_bad_cycles", bad, 0);
        #1 chk("after_flush", {busy, miss_ready}, {1'b0, 1'b1});
        step();
        miss_valid = 1'b0;
        #1 chk("miss_after_flush_busy", busy, 1);
        step();
        #1 chk("rfill_inval_way", {tw_en, tw_way, tw_line}, {1'b1, 2'd0, 8'h45});
        step();
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'h1000 + b;
            dw_q.push_back({2'd0, 8'h45, 2'(b), 32'h1000 + b});
            step();
        end
        mem_rsp_valid = 1'b0;
        rst = 1'b1;
        #1 chk("rst_midfill_outputs",
               {busy, miss_ready, tw_en, lru_we, dw_en, fill_done, mem_req_valid}, 0);
        step();
        rst = 1'b0;
        #1 chk("rst_midfill_idle", {busy, miss_ready}, {1'b0, 1'b1});
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hdead_beef;
        #1 chk("stray_rsp_dw_en", dw_en, 0);
        step();
        mem_rsp_valid = 1'b0;
        step();
        chk("dw_queue_empty", dw_q.size(), 0);
        chk("fill_done_final", fill_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ic_refill_ctrl.md
IC_REFILL_CTRL -- requirements
Module: ic_refill_ctrl

Interface
REQ-001 SHALL have: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: miss_valid in 1 / miss_ready out 1 / miss_addr in ADDR_BITS: miss request handshake, byte address.
REQ-004 SHALL have: flush_req in 1 / flush_done out 1: whole-cache invalidate request / one-cycle completion pulse.
REQ-005 SHALL have: lk_line out ic_line_t / lk_lru in ic_lru_t / lk_valid in WAYS: LRU and valid-bit lookup, 1-cycle read latency.
REQ-006 SHALL have: mem_req_valid out 1 / mem_req_ready in 1 / mem_req_addr out ADDR_BITS: line-fetch request.
REQ-007 SHALL have: mem_rsp_valid in 1 / mem_rsp_data in 32: response beats, no backpressure.
REQ-008 SHALL have: dw_en out 1 / dw_way out ic_way_t / dw_line out ic_line_t / dw_word out ic_waddr_t / dw_data out 32: data-memory write; dw_data[15:0] to even memory, [31:16] to odd.
REQ-009 SHALL have: tw_en out 1 / tw_all out 1 / tw_way out ic_way_t / tw_line out ic_line_t / tw_entry out ic_tag_entry_t: tag write; tw_all writes every way.
REQ-010 SHALL have: lru_we out 1 / lru_line out ic_line_t / lru_wdata out ic_lru_t: LRU write.
REQ-011 SHALL have: busy out 1 (state != IDLE), fill_done out 1 pulse, fill_way out ic_way_t.

Function
REQ-012 SHALL implement states IDLE, FLUSH, LOOKUP, INVAL, REQ, FILL, COMMIT.
REQ-013 IDLE: miss_ready=1 iff !flush_req; flush_req takes priority over a simultaneous miss_valid.
REQ-014 lk_line SHALL equal miss_addr[11:4] in IDLE, captured line otherwise.
REQ-015 Miss accept (miss_valid&&miss_ready): capture tag=addr[26:12], line=addr[11:4]; -> LOOKUP; addr[3:0] ignored.
REQ-016 LOOKUP (1 cycle): victim = lowest-index way with lk_valid=0; if all valid, way whose lk_lru rank == WAYS-1; capture lk_lru; -> INVAL.
REQ-017 INVAL (1 cycle): tw_en=1, tw_way=victim, tw_entry.valid=0, so a partial line never hits; -> REQ.
REQ-018 REQ: mem_req_valid=1, mem_req_addr={tag,line,4'b0}, held stable until mem_req_ready; -> FILL on handshake cycle.
REQ-019 FILL: each mem_rsp_valid cycle SHALL drive dw_en=1 same cycle, dw_data=mem_rsp_data, dw_word=beat counter, dw_way=victim, dw_line=line; counter 0..3 then wraps to 0; after beat 3 -> COMMIT.
REQ-020 mem_rsp_valid outside FILL SHALL be ignored.
REQ-021 COMMIT (1 cycle): tw_en=1, tw_entry={1,tag}; lru_we=1, lru_wdata: victim rank 0, ways with rank < old victim rank +1, others unchanged; fill_done=1, fill_way=victim; -> IDLE.
REQ-022 Miss latency: accept at T -> mem_req_valid at T+3 earliest; fill_done one cycle after last beat.
REQ-023 FLUSH: counter 0..255; each cycle tw_en=1, tw_all=1, tw_entry.valid=0, tw_line=counter; lru_we=1, lru_wdata rank(way i)=i; at 255 pulse flush_done, counter wraps to 0, -> IDLE (256 cycles total).
REQ-024 flush_req SHALL be sampled only in IDLE; assertion during a fill is held off until IDLE.
REQ-025 All write enables and pulses SHALL be 0 in states not listed as asserting them.

Reset
REQ-026 rst high SHALL force IDLE, beat and flush counters 0, all outputs 0 including miss_ready, next cycle after release miss_ready=1.
REQ-027 Reset mid-FILL/FLUSH SHALL abandon operation with no further tag/LRU writes; line stays invalid.

Verification
REQ-028 Miss addr 0x0123450, lk_valid=4'b1011 -> victim 2, INVAL tw_line 0x45, mem_req_addr 0x0123450, COMMIT tag 0x0123.
REQ-029 All valid, lk_lru ranks {w3:1,w2:3,w1:0,w0:2} -> victim 2; lru_wdata {w3:2,w2:0,w1:1,w0:3}.
REQ-030 mem_req_ready low 5 cycles -> mem_req_valid/addr stable; beats with gaps -> dw_word 0,1,2,3, fill_done once.
REQ-031 flush_req and miss_valid same IDLE cycle -> miss_ready=0, 256 tag writes lines 0..255, flush_done at cycle 256, then miss accepted.
REQ-032 rst after beat 1 -> no COMMIT writes, outputs 0, IDLE next cycle; stray mem_rsp_valid in IDLE -> no dw_en.
